// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared core package. Holds the pipeline-control FSM state
//                encodings, the default memory-wait timeout, the register-file
//                write-back select encodings, the bundled control word, and a
//                helper that builds the normal-flow (RUN) control word.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_STATE_W         = 2;
    localparam int c_TIMEOUT_DEFAULT = 255;

    typedef enum logic [c_STATE_W-1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    // Register-file write-back source select
    typedef enum logic [1:0] {
        RF_SEL_ALU = 2'b00,
        RF_SEL_MEM = 2'b01,
        RF_SEL_PC4 = 2'b10,
        RF_SEL_IMM = 2'b11
    } rf_sel_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_we;
    } ctl_t;

    // Control word for a cycle in which the pipeline is allowed to move.
    // A taken branch squashes the two younger stages and wins over a
    // load-use stall, since the stalled instruction is on the wrong path.
    function automatic ctl_t run_ctl(input logic stall_lu, input logic branch);
        ctl_t c;
        c = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
              id_ex_flush: 1'b0, ex_mem_we: 1'b1, mem_wb_we: 1'b1};
        if (branch) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (stall_lu) begin
            c.pc_we       = 1'b0;
            c.if_id_we    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_if
//  Description : Hazard/memory event inputs and pipeline control outputs of
//                the pipeline controller.
//                master : drives events, observes controls (hazard sources)
//                slave  : the controller itself
//  Ports       : stall_lu, branch_taken_EX, dmem_req, dmem_ready (events)
//                pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we,
//                mem_wb_we, mem_err, state_o, stall_cnt, flush_cnt (controls)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_ctrl_pkg::*;

    logic                 stall_lu;
    logic                 branch_taken_EX;
    logic                 dmem_req;
    logic                 dmem_ready;
    logic                 pc_we;
    logic                 if_id_we;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 ex_mem_we;
    logic                 mem_wb_we;
    logic                 mem_err;
    logic [c_STATE_W-1:0] state_o;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output stall_lu, branch_taken_EX, dmem_req, dmem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
        input  mem_err, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall_lu, branch_taken_EX, dmem_req, dmem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
        output mem_err, state_o, stall_cnt, flush_cnt
    );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones, with synchronous clear.
//  Ports       : clk   - clock
//                clr   - synchronous clear (dominates inc)
//                inc   - increment enable
//                count - current value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Five-stage pipeline stall/flush controller. Mealy outputs
//                from the FSM state and same-cycle events; freezes the whole
//                pipeline on an outstanding data-memory access, halts if the
//                access exceeds TIMEOUT wait cycles, and keeps saturating
//                stall/flush performance counters.
//  Ports       : clk - clock, rst - synchronous active-high reset,
//                bus - pipeline_ctrl_if.slave (events in, controls out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input wire logic        clk,
    input wire logic        rst,
    pipeline_ctrl_if.slave  bus
);

    // Wide enough to hold TIMEOUT-1, the last wait count before halting
    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_next;
    ctl_t                w_ctl;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;
    logic                w_stall_inc;

    always_comb begin
        w_next = r_state;
        w_ctl  = '0;
        case (r_state)
            ST_RUN: begin
                // An unfinished memory access freezes every stage; it beats
                // both branch and load-use since nothing may advance.
                if (bus.dmem_req && !bus.dmem_ready) begin
                    w_next = ST_MEM_WAIT;
                end else begin
                    w_ctl = run_ctl(bus.stall_lu, bus.branch_taken_EX);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    w_ctl  = run_ctl(bus.stall_lu, bus.branch_taken_EX);
                    w_next = ST_RUN;
                end else if (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1)) begin
                    w_next = ST_HALT;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_HALT;
            end
        endcase
        if (rst) begin
            w_ctl = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            // Counts consecutive not-ready cycles spent in MEM_WAIT
            r_wait_cnt <= (r_state == ST_MEM_WAIT && w_next == ST_MEM_WAIT) ?
                          r_wait_cnt + 1'b1 : '0;
            r_mem_err  <= r_mem_err | (w_next == ST_HALT);
        end
    end

    assign w_stall_inc = (r_state != ST_HALT) && !w_ctl.pc_we;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_ctl.if_id_flush),
        .count (bus.flush_cnt)
    );

    assign bus.pc_we       = w_ctl.pc_we;
    assign bus.if_id_we    = w_ctl.if_id_we;
    assign bus.if_id_flush = w_ctl.if_id_flush;
    assign bus.id_ex_flush = w_ctl.id_ex_flush;
    assign bus.ex_mem_we   = w_ctl.ex_mem_we;
    assign bus.mem_wb_we   = w_ctl.mem_wb_we;
    assign bus.mem_err     = r_mem_err;
    assign bus.state_o     = r_state;

endmodule : pipeline_ctrl
`default_nettype wire
